// File: rtl/redmule_pkg.sv
// Shared RedMulE types: the wide TCDM request/response port and the read-response
// entry carried through the responder's pipeline and FIFO.
package redmule_pkg;

  localparam int unsigned DATA_W  = 512;
  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned BOFFS_W = 4;
  localparam int unsigned USER_W  = 1;

  localparam logic TCDM_RSP_OK  = 1'b0;
  localparam logic TCDM_RSP_ERR = 1'b1;

  typedef struct packed {
    logic              req;
    logic              wen;
    logic [BE_W-1:0]   be;
    logic [BOFFS_W-1:0] boffs;
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] data;
    logic              lrdy;
    logic [USER_W-1:0] user;
  } redmule_default_data_req_t;

  typedef struct packed {
    logic              gnt;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_opc;
    logic [USER_W-1:0] r_user;
  } redmule_default_data_rsp_t;

  typedef struct packed {
    logic [DATA_W-1:0] r_data;
    logic              r_opc;
    logic [USER_W-1:0] r_user;
  } tcdm_rd_entry_t;

endpackage

// File: rtl/redmule_tcdm_rsp_fifo.sv
// Fall-through response FIFO: an entry pushed into an empty FIFO is visible on the
// output in the same cycle, so an unstalled consumer sees no extra latency.
module redmule_tcdm_rsp_fifo
  import redmule_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_valid_i,
  input  tcdm_rd_entry_t push_data_i,
  input  logic           pop_ready_i,
  output logic           valid_o,
  output tcdm_rd_entry_t data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  tcdm_rd_entry_t  store [Depth];
  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic [CntW-1:0] count;
  logic            empty;
  logic            bypass;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count == '0);
  assign valid_o = ~empty | push_valid_i;
  assign data_o  = empty ? push_data_i : store[rptr];

  // An entry consumed in the cycle it arrives at an empty FIFO never gets stored.
  assign bypass  = empty & push_valid_i & pop_ready_i;
  assign do_push = push_valid_i & ~bypass;
  assign do_pop  = ~empty & pop_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_next(wptr);
      if (do_pop)  rptr <= ptr_next(rptr);
      count <= count + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) store[wptr] <= push_data_i;
  end

endmodule

// File: rtl/redmule_tcdm_responder.sv
// TCDM memory model for RedMulE: byte-enabled writes, fixed-latency reads through a
// pipeline and credit-gated response FIFO, with stall injection on the grant.
module redmule_tcdm_responder
  import redmule_pkg::*;
#(
  parameter int unsigned NumWords     = 1024,
  parameter int unsigned RdLatency    = 2,
  parameter int unsigned RspFifoDepth = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      stall_i,
  input  redmule_default_data_req_t tcdm_req_i,
  output redmule_default_data_rsp_t tcdm_rsp_o,
  output logic                      busy_o
);

  // Handshake: a transfer happens in any cycle where req and gnt are both high.
  // Read responses are offered on r_valid and consumed on r_valid & lrdy.

  localparam int unsigned OffsW = $clog2(BE_W);
  localparam int unsigned IdxW  = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned CntW  = $clog2(RspFifoDepth + 1);

  logic [DATA_W-1:0] mem [NumWords];

  logic [ADDR_W-1:0] word_idx;
  logic [IdxW-1:0]   mem_idx;
  logic              in_range;
  logic [CntW-1:0]   outstanding;
  logic              credit_ok;
  logic              gnt;
  logic              rd_grant;
  logic              wr_grant;
  logic              pop;
  tcdm_rd_entry_t    rd_entry;

  logic [RdLatency-1:0] pipe_valid;
  tcdm_rd_entry_t       pipe_data [RdLatency];

  logic           fifo_valid;
  tcdm_rd_entry_t fifo_head;

  logic unused_req_bits;
  assign unused_req_bits = ^{tcdm_req_i.boffs, tcdm_req_i.add[OffsW-1:0]};

  assign word_idx  = tcdm_req_i.add >> OffsW;
  assign mem_idx   = word_idx[IdxW-1:0];
  assign in_range  = (word_idx < ADDR_W'(NumWords));
  assign credit_ok = (outstanding < CntW'(RspFifoDepth));

  // Credits count everything in the pipeline plus the FIFO, so the FIFO cannot overflow.
  assign gnt      = tcdm_req_i.req & ~stall_i & rst_ni & (~tcdm_req_i.wen | credit_ok);
  assign rd_grant = gnt & tcdm_req_i.wen;
  assign wr_grant = gnt & ~tcdm_req_i.wen;

  always_ff @(posedge clk_i) begin
    if (wr_grant && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (tcdm_req_i.be[b]) mem[mem_idx][b*8 +: 8] <= tcdm_req_i.data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_entry.r_user = tcdm_req_i.user;
    if (in_range) begin
      rd_entry.r_data = mem[mem_idx];
      rd_entry.r_opc  = TCDM_RSP_OK;
    end else begin
      rd_entry.r_data = '0;
      rd_entry.r_opc  = TCDM_RSP_ERR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= rd_grant;
      for (int i = 1; i < RdLatency; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_grant) pipe_data[0] <= rd_entry;
    for (int i = 1; i < RdLatency; i++) begin
      if (pipe_valid[i-1]) pipe_data[i] <= pipe_data[i-1];
    end
  end

  redmule_tcdm_rsp_fifo #(
    .Depth(RspFifoDepth)
  ) i_rsp_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_valid_i(pipe_valid[RdLatency-1]),
    .push_data_i (pipe_data[RdLatency-1]),
    .pop_ready_i (tcdm_req_i.lrdy & rst_ni),
    .valid_o     (fifo_valid),
    .data_o      (fifo_head)
  );

  assign pop = fifo_valid & tcdm_req_i.lrdy & rst_ni;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else begin
      case ({rd_grant, pop})
        2'b10:   outstanding <= outstanding + CntW'(1);
        2'b01:   outstanding <= outstanding - CntW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Registered state may still hold stale values during the reset cycle; mask outputs.
  always_comb begin
    tcdm_rsp_o.gnt     = gnt;
    tcdm_rsp_o.r_valid = fifo_valid & rst_ni;
    tcdm_rsp_o.r_data  = rst_ni ? fifo_head.r_data : '0;
    tcdm_rsp_o.r_opc   = rst_ni ? fifo_head.r_opc  : 1'b0;
    tcdm_rsp_o.r_user  = rst_ni ? fifo_head.r_user : '0;
  end

  assign busy_o = rst_ni & (outstanding != '0);

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Randomized and directed bench for redmule_tcdm_responder: a monitor keeps a
// word-array memory model and an expected-response queue, checking every cycle.
module tb_redmule_tcdm_responder;
  import redmule_pkg::*;

  localparam int NW    = 1024;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int EW    = DATA_W + 2;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic stall = 1'b0;
  logic busy;
  redmule_default_data_req_t req;
  redmule_default_data_rsp_t rsp;

  redmule_tcdm_responder #(
    .NumWords    (NW),
    .RdLatency   (LAT),
    .RspFifoDepth(DEPTH)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .stall_i   (stall),
    .tcdm_req_i(req),
    .tcdm_rsp_o(rsp),
    .busy_o    (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] model_mem [NW];
  int                model_out = 0;
  int                checks = 0;
  int                failures = 0;
  bit                rand_mode = 0;
  bit                prev_hold = 0;
  logic [EW-1:0]     prev_rsp;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] cur;
    int            idx;
    bit            exp_gnt;
    cur = {rsp.r_data, rsp.r_opc, rsp.r_user};
    if (!rst_ni) begin
      chk("rst_gnt", EW'(rsp.gnt), '0);
      chk("rst_rvalid", EW'(rsp.r_valid), '0);
      chk("rst_rsp", cur, '0);
      chk("rst_busy", EW'(busy), '0);
      exp_q.delete();
      model_out = 0;
      prev_hold = 0;
    end else begin
      exp_gnt = req.req && !stall && (!req.wen || model_out < DEPTH);
      chk("gnt", EW'(rsp.gnt), EW'(exp_gnt));
      chk("busy", EW'(busy), EW'(model_out != 0));
      if (prev_hold) begin
        chk("hold_valid", EW'(rsp.r_valid), EW'(1));
        chk("hold_stable", cur, prev_rsp);
      end
      if (rsp.r_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", EW'(rsp.r_valid), '0);
        end else if (req.lrdy) begin
          chk("rsp", cur, exp_q.pop_front());
          model_out--;
        end
      end
      if (req.req && rsp.gnt) begin
        idx = int'(req.add / BE_W);
        if (req.wen) begin
          if (idx < NW) exp_q.push_back({model_mem[idx], TCDM_RSP_OK, req.user});
          else          exp_q.push_back({{DATA_W{1'b0}}, TCDM_RSP_ERR, req.user});
          model_out++;
        end else if (idx < NW) begin
          for (int b = 0; b < BE_W; b++)
            if (req.be[b]) model_mem[idx][b*8 +: 8] = req.data[b*8 +: 8];
        end
      end
      prev_hold = rsp.r_valid && !req.lrdy;
      prev_rsp  = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ctl();
    stall    = ($urandom_range(0, 4) == 0);
    req.lrdy = ($urandom_range(0, 3) != 0);
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic wait_gnt(output int gcyc);
    bit ok;
    ok = 0;
    gcyc = -1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (rsp.gnt) begin
        ok = 1;
        gcyc = cyc;
      end
      tick();
      if (!ok && rand_mode) randomize_ctl();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout act=no grant in 64 cycles exp=grant");
    end
    req.req = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    int g;
    req.req   = 1'b1;
    req.wen   = 1'b0;
    req.add   = a;
    req.data  = d;
    req.be    = be;
    req.boffs = BOFFS_W'($urandom_range(0, 15));
    req.user  = '0;
    wait_gnt(g);
  endtask

  task automatic do_read(input logic [31:0] a, input logic u, output int g);
    req.req   = 1'b1;
    req.wen   = 1'b1;
    req.add   = a;
    req.data  = rand_word();
    req.be    = '1;
    req.boffs = BOFFS_W'($urandom_range(0, 15));
    req.user  = u;
    wait_gnt(g);
  endtask

  task automatic drain();
    req.lrdy = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    chk("drain_left", EW'(exp_q.size()), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    int ng;
    int nv;
    int vcyc;
    int idx;
    logic [DATA_W-1:0] pat_a;

    req = '0;
    req.lrdy = 1'b1;
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();

    // Fill the whole store so every model word is known.
    for (int w = 0; w < NW; w++) do_write(32'(w * BE_W), rand_word(), '1);

    // Write then read the next cycle; response must arrive LAT cycles after grant.
    pat_a = rand_word();
    do_write(32'h40, pat_a, '1);
    do_read(32'h40, 1'b0, g);
    vcyc = -1;
    for (int i = 0; i < 20 && vcyc < 0; i++) begin
      @(negedge clk);
      if (rsp.r_valid) vcyc = cyc;
      tick();
    end
    chk("rd_latency", EW'(vcyc - g), EW'(LAT));

    // Partial write of the low four bytes over a zeroed word.
    do_write(32'h80, '0, '1);
    do_write(32'h80, '1, 64'h0000_0000_0000_000F);
    do_read(32'h80, 1'b0, g);

    // Out-of-range read and write.
    do_read(32'(NW * BE_W), 1'b1, g);
    do_write(32'(NW * BE_W), rand_word(), '1);
    do_read(32'h0, 1'b0, g);
    drain();

    // Backpressure: six back-to-back reads with lrdy low, only DEPTH granted.
    req.lrdy = 1'b0;
    ng = 0;
    for (int i = 0; i < 6; i++) begin
      req.req  = 1'b1;
      req.wen  = 1'b1;
      req.add  = 32'((i + 3) * BE_W);
      req.user = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rsp.gnt) ng++;
      tick();
    end
    chk("bp_grants", EW'(ng), EW'(DEPTH));
    @(negedge clk);
    chk("bp_gnt_blocked", EW'(rsp.gnt), '0);
    tick();
    req.req  = 1'b0;
    req.lrdy = 1'b1;
    nv = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (rsp.r_valid) nv++;
      tick();
    end
    chk("bp_burst", EW'(nv), EW'(DEPTH));
    drain();

    // Stall injection with user bit set.
    stall    = 1'b1;
    req.req  = 1'b1;
    req.wen  = 1'b1;
    req.add  = 32'h40;
    req.user = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_gnt", EW'(rsp.gnt), '0);
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("stall_release", EW'(rsp.gnt), EW'(1));
    tick();
    req.req = 1'b0;
    drain();

    // Randomized traffic with stall and lrdy jitter.
    rand_mode = 1;
    for (int n = 0; n < 400; n++) begin
      randomize_ctl();
      idx = ($urandom_range(0, 15) == 0) ? NW + int'($urandom_range(0, 15)) : int'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: tick();
        1: do_write(32'(idx * BE_W + int'($urandom_range(0, 63))), rand_word(),
                    {$urandom(), $urandom()});
        default: do_read(32'(idx * BE_W + int'($urandom_range(0, 63))), 1'($urandom_range(0, 1)), g);
      endcase
    end
    rand_mode = 0;
    drain();

    // Mid-operation reset with two reads in flight.
    req.lrdy = 1'b0;
    do_read(32'h140, 1'b1, g);
    do_read(32'h180, 1'b0, g);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    req.lrdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", EW'(rsp.r_valid), '0);
      chk("post_rst_busy", EW'(busy), '0);
      tick();
    end
    do_read(32'h40, 1'b0, g);
    do_read(32'h80, 1'b1, g);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/redmule_tcdm_responder.md
REDMULE_TCDM_RESPONDER -- requirements
Module: redmule_tcdm_responder

Interface
REQ-001 SHALL have parameter NumWords, default 1024: depth of the backing store in DATA_W-bit words.
REQ-002 SHALL have parameter RdLatency, default 2: cycles from read grant to r_valid when no backpressure applies; legal range 1..8.
REQ-003 SHALL have parameter RspFifoDepth, default 4: maximum outstanding reads; legal minimum RdLatency.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port stall_i, input, 1 bit: when high, grant is suppressed (contention injection).
REQ-007 SHALL have port tcdm_req_i, input, redmule_default_data_req_t: wide-port request (req, wen, be, boffs, add, data, lrdy, user).
REQ-008 SHALL have port tcdm_rsp_o, output, redmule_default_data_rsp_t: wide-port response (gnt, r_valid, r_data, r_opc, r_user).
REQ-009 SHALL have port busy_o, output, 1 bit: high while any read is outstanding.

Function
REQ-010 SHALL compute gnt combinationally as req & ~stall_i & rst_ni & (wen=0 | outstanding < RspFifoDepth).
REQ-011 SHALL treat wen=1 as read and wen=0 as write; a transfer occurs only when req & gnt are both high in a cycle.
REQ-012 SHALL derive the word index as add >> log2(DATA_W/8); the low address bits and boffs are ignored.
REQ-013 SHALL, on a granted write with index < NumWords, update exactly the bytes whose be bit is set at that clock edge; writes produce no response.
REQ-014 SHALL discard a granted write with index >= NumWords with no memory change and no response.
REQ-015 SHALL, on a granted read, sample the memory word at the grant edge, so a read granted the cycle after a write returns the written data.
REQ-016 SHALL return r_data=0 and r_opc=1 for a read with index >= NumWords; r_opc=0 otherwise.
REQ-017 SHALL echo the request user bit on r_user of the matching response.
REQ-018 SHALL carry read results through a RdLatency-stage valid/data pipeline into a response FIFO of depth RspFifoDepth.
REQ-019 SHALL drive r_valid high whenever the FIFO is non-empty, present the FIFO head on r_data/r_opc/r_user, and pop on r_valid & lrdy.
REQ-020 SHALL, with lrdy held high and the FIFO empty, assert r_valid exactly RdLatency cycles after the grant cycle (FIFO bypass timing).
REQ-021 SHALL hold r_data, r_opc, and r_user stable while r_valid=1 and lrdy=0.
REQ-022 SHALL deliver read responses strictly in grant order.
REQ-023 SHALL maintain outstanding as a counter: +1 on a read grant, -1 on a pop, unchanged when both occur in the same cycle.
REQ-024 SHALL never overflow the FIFO; REQ-010 credit gating guarantees this by construction.
REQ-025 SHALL drive busy_o = (outstanding != 0).

Reset
REQ-026 SHALL, on rst_ni=0 at a clock edge, clear the pipeline valids, the FIFO, and the outstanding counter.
REQ-027 SHALL hold gnt, r_valid, r_data, r_opc, r_user, and busy_o at 0 while in reset; in-flight reads are dropped without response.
REQ-028 SHALL NOT clear memory contents on reset.

Structure
REQ-029 SHALL add to redmule_pkg the constants TCDM_RSP_OK=1'b0 and TCDM_RSP_ERR=1'b1, and a packed struct tcdm_rd_entry_t {r_data, r_opc, r_user}.
REQ-030 SHALL reuse redmule_default_data_req_t and redmule_default_data_rsp_t unchanged.
REQ-031 SHALL implement the response FIFO as the single sub-module redmule_tcdm_rsp_fifo, storing tcdm_rd_entry_t, with synchronous active-low reset.

Verification
REQ-032 SHALL cover write/readback: write add=0x40, be=all-ones, data=pattern A; read add=0x40 next cycle -> r_valid at grant+2 with r_data=A, r_opc=0.
REQ-033 SHALL cover partial write: be=0x0000_0000_0000_000F, data=all-ones over a zeroed word -> readback has low 4 bytes=0xFF and all other bytes 0.
REQ-034 SHALL cover out-of-range read: read add=NumWords*64 -> r_opc=1, r_data=0; an out-of-range write leaves word 0 unchanged.
REQ-035 SHALL cover backpressure: issue 6 back-to-back reads with lrdy=0 -> exactly 4 granted, gnt=0 afterwards; then raise lrdy -> 4 in-order responses, one per cycle, data stable while stalled.
REQ-036 SHALL cover stall: stall_i=1 with req=1 for 3 cycles -> gnt=0; stall_i=0 -> grant on the next cycle; r_user=1 echoed.
REQ-037 SHALL cover mid-operation reset: 2 reads outstanding, rst_ni=0 for 1 cycle -> no r_valid afterwards, busy_o=0, memory contents retained.
